// File: rtl/fuzz_stim_pkg.sv
// ---------------------------------------------------------------------------
// fuzz_stim_pkg
// Shared constants, FSM state type and LCG step function for the stimulus
// generator that feeds the fuzz top. The LCG constants must stay in lockstep
// with the software stimulus stream so hardware and software runs agree
// bit-for-bit for the same seed.
// No ports (package).
// ---------------------------------------------------------------------------
package fuzz_stim_pkg;

  localparam int          WORD_W       = 32;
  localparam logic [31:0] LCG_MUL      = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC      = 32'h00003039;
  localparam logic [31:0] DEFAULT_SEED = 32'd2555656321;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } stim_state_e;

  // One LCG step; the multiply is evaluated at 32 bits, so the product wraps
  // exactly like the unsigned 32-bit arithmetic of the software model.
  function automatic logic [31:0] lcg_step(input logic [31:0] state);
    return state * LCG_MUL + LCG_INC;
  endfunction

endpackage

// File: rtl/lcg32_core.sv
// ---------------------------------------------------------------------------
// lcg32_core
// 32-bit linear congruential generator state register.
// Ports:
//   clk        in   1   clock, posedge
//   rst_n      in   1   asynchronous active-low reset (state -> 0)
//   i_load     in   1   load i_seed into the state (has priority over advance)
//   i_seed     in   32  value loaded on i_load
//   i_advance  in   1   replace the state with its successor
//   o_rng      out  32  current state
//   o_rng_next out  32  successor of the current state (combinational)
// ---------------------------------------------------------------------------
module lcg32_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_seed,
  input  logic        i_advance,
  output logic [31:0] o_rng,
  output logic [31:0] o_rng_next
);

  import fuzz_stim_pkg::*;

  logic [31:0] r_rng;
  logic [31:0] w_step;

  assign w_step     = lcg_step(r_rng);
  assign o_rng      = r_rng;
  assign o_rng_next = w_step;

  // Load wins over advance so a new run always starts from its seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rng <= 32'd0;
    end else if (i_load) begin
      r_rng <= i_seed;
    end else if (i_advance) begin
      r_rng <= w_step;
    end
  end

endmodule

// File: rtl/lcg_stim_gen.sv
// ---------------------------------------------------------------------------
// lcg_stim_gen
// Pseudo-random stimulus source for the fuzz top's in_flat port. One LCG
// step per FILL cycle yields one 32-bit word; words are packed low word first
// into an IN_W-bit vector which is then offered over valid/ready.
// Ports:
//   clk          in   1     clock, posedge
//   rst_n        in   1     asynchronous active-low reset
//   start        in   1     begin a run (honoured only in IDLE or DONE)
//   seed_i       in   32    run seed, sampled on start; 0 selects DEFAULT_SEED
//   num_vec_i    in   32    number of vectors in the run, sampled on start
//   vec_o        out  IN_W  current vector, stable while vec_valid_o=1
//   vec_valid_o  out  1     vector available
//   vec_ready_i  in   1     consumer takes vec_o when valid&ready at posedge
//   busy_o       out  1     run in progress (FILL or HOLD)
//   done_o       out  1     run complete, held until the next start
//   vec_count_o  out  32    vectors accepted in the current run
//   rng_o        out  32    current LCG state (trace)
// ---------------------------------------------------------------------------
module lcg_stim_gen #(
  parameter int          IN_W         = 263,
  parameter logic [31:0] DEFAULT_SEED = fuzz_stim_pkg::DEFAULT_SEED
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [31:0]     seed_i,
  input  logic [31:0]     num_vec_i,
  output logic [IN_W-1:0] vec_o,
  output logic            vec_valid_o,
  input  logic            vec_ready_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [31:0]     vec_count_o,
  output logic [31:0]     rng_o
);

  import fuzz_stim_pkg::*;

  localparam int NUM_WORDS = (IN_W + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = IN_W - WORD_W * (NUM_WORDS - 1);
  localparam int LAST_IDX  = NUM_WORDS - 1;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  stim_state_e                         r_state;
  logic [IDX_W-1:0]                    r_word_idx;
  logic [NUM_WORDS-2:0][WORD_W-1:0]    r_shadow;
  logic [31:0]                         r_num_vec;
  logic [31:0]                         r_vec_count;
  logic [IN_W-1:0]                     r_vec;
  logic                                r_valid;
  logic                                r_busy;
  logic                                r_done;

  logic        w_start_ok;
  logic        w_advance;
  logic        w_last_word;
  logic [31:0] w_seed;
  logic [31:0] w_rng;
  logic [31:0] w_rng_next;
  logic [IN_W-1:0] w_fill_vec;

  // A start pulse is only meaningful when no run is in flight.
  assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_advance   = (r_state == FILL);
  assign w_last_word = (r_word_idx == IDX_W'(LAST_IDX));
  assign w_seed      = (seed_i == 32'd0) ? DEFAULT_SEED : seed_i;

  // The final word is taken straight from the step being produced this
  // cycle, so the vector is complete on the same edge the last word appears;
  // only its low LAST_BITS bits fit inside IN_W.
  assign w_fill_vec = {w_rng_next[LAST_BITS-1:0], r_shadow};

  lcg32_core u_lcg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_start_ok),
    .i_seed     (w_seed),
    .i_advance  (w_advance),
    .o_rng      (w_rng),
    .o_rng_next (w_rng_next)
  );

  // Run control. IDLE/DONE wait for start; FILL gathers NUM_WORDS words;
  // HOLD freezes the vector until the consumer takes it, then either refills
  // or finishes. All handshake and status outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_word_idx  <= '0;
      r_shadow    <= '0;
      r_num_vec   <= 32'd0;
      r_vec_count <= 32'd0;
      r_vec       <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_num_vec   <= num_vec_i;
            r_vec_count <= 32'd0;
            r_word_idx  <= '0;
            if (num_vec_i == 32'd0) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= FILL;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end

        FILL: begin
          for (int w = 0; w < NUM_WORDS - 1; w++) begin
            if (r_word_idx == IDX_W'(w)) begin
              r_shadow[w] <= w_rng_next;
            end
          end
          if (w_last_word) begin
            r_vec      <= w_fill_vec;
            r_valid    <= 1'b1;
            r_word_idx <= '0;
            r_state    <= HOLD;
          end else begin
            r_word_idx <= r_word_idx + IDX_W'(1);
          end
        end

        HOLD: begin
          if (vec_ready_i) begin
            r_valid     <= 1'b0;
            r_vec_count <= r_vec_count + 32'd1;
            if ((r_vec_count + 32'd1) == r_num_vec) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= FILL;
            end
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign vec_o       = r_vec;
  assign vec_valid_o = r_valid;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign vec_count_o = r_vec_count;
  assign rng_o       = w_rng;

endmodule

// File: tb/tb_lcg_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_lcg_stim_gen
// Directed bench for lcg_stim_gen. A second instance with DEFAULT_SEED
// overridden to 0 exercises the default-seed path against hand-computed
// words. Expected vectors come from a 64-bit software LCG model.
// ---------------------------------------------------------------------------
module tb_lcg_stim_gen;

  localparam logic [31:0] SEED_A = 32'd2555656321;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         start0 = 1'b0;
  logic [31:0]  seed_i = 32'd0;
  logic [31:0]  num_vec_i = 32'd0;
  logic         vec_ready_i = 1'b0;

  logic [262:0] vec_o;
  logic         vec_valid_o;
  logic         busy_o;
  logic         done_o;
  logic [31:0]  vec_count_o;
  logic [31:0]  rng_o;

  logic [262:0] vec0;
  logic         valid0;
  logic         busy0;
  logic         done0;
  logic [31:0]  count0;
  logic [31:0]  rng0;

  int testsRun = 0;
  int testsFailed = 0;

  lcg_stim_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .seed_i      (seed_i),
    .num_vec_i   (num_vec_i),
    .vec_o       (vec_o),
    .vec_valid_o (vec_valid_o),
    .vec_ready_i (vec_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .vec_count_o (vec_count_o),
    .rng_o       (rng_o)
  );

  lcg_stim_gen #(.DEFAULT_SEED(32'd0)) dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start0),
    .seed_i      (seed_i),
    .num_vec_i   (num_vec_i),
    .vec_o       (vec0),
    .vec_valid_o (valid0),
    .vec_ready_i (vec_ready_i),
    .busy_o      (busy0),
    .done_o      (done0),
    .vec_count_o (count0),
    .rng_o       (rng0)
  );

  always #5 clk = ~clk;

  // Software LCG reference, computed in 64 bits and truncated.
  function automatic logic [31:0] model_step(input logic [31:0] x);
    logic [63:0] p;
    p = 64'(x) * 64'd1103515245 + 64'd12345;
    return p[31:0];
  endfunction

  task automatic model_vec(inout logic [31:0] st, output logic [262:0] v);
    logic [287:0] acc;
    acc = '0;
    for (int k = 0; k < 9; k++) begin
      st = model_step(st);
      acc[k*32 +: 32] = st;
    end
    v = acc[262:0];
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int limit, output int cycles, output bit ok);
    cycles = 0;
    while (!vec_valid_o && cycles < limit) begin
      tick(1);
      cycles++;
    end
    ok = vec_valid_o;
  endtask

  task automatic pulse_start(input logic [31:0] seed, input logic [31:0] num);
    seed_i = seed;
    num_vec_i = num;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_reset();
    start = 1'b0;
    start0 = 1'b0;
    vec_ready_i = 1'b0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(1);
    testsRun++;
    if (vec_o !== '0 || vec_valid_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_vec: vec=%h valid=%b expected 0/0", vec_o, vec_valid_o);
    end
    testsRun++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_status: busy=%b done=%b expected 0/0", busy_o, done_o);
    end
    testsRun++;
    if (vec_count_o !== 32'd0 || rng_o !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_count_rng: count=%0d rng=%h expected 0/0", vec_count_o, rng_o);
    end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_default_seed();
    logic [31:0]  st;
    logic [262:0] exp;
    int           cyc;
    bit           ok;
    do_reset();
    seed_i = 32'd0;
    num_vec_i = 32'd1;
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    testsRun++;
    if (rng0 !== 32'd0 || busy0 !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL dflt0_start: rng=%h busy=%b expected 0/1", rng0, busy0);
    end
    tick(8);
    testsRun++;
    if (valid0 !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL dflt0_early_valid: valid=%b expected 0", valid0);
    end
    tick(1);
    testsRun++;
    if (valid0 !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL dflt0_latency: valid=%b expected 1", valid0);
    end
    testsRun++;
    if (vec0[31:0] !== 32'h00003039 || vec0[63:32] !== 32'hD3DC167E) begin
      testsFailed++;
      $display("[TB] FAIL dflt0_words: w0=%h w1=%h expected 00003039/d3dc167e", vec0[31:0], vec0[63:32]);
    end
    st = 32'd0;
    model_vec(st, exp);
    testsRun++;
    if (vec0 !== exp) begin
      testsFailed++;
      $display("[TB] FAIL dflt0_vec: got %h expected %h", vec0, exp);
    end
    vec_ready_i = 1'b1;
    tick(1);
    vec_ready_i = 1'b0;
    testsRun++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || valid0 !== 1'b0 || count0 !== 32'd1) begin
      testsFailed++;
      $display("[TB] FAIL dflt0_done: done=%b busy=%b valid=%b count=%0d expected 1/0/0/1", done0, busy0, valid0, count0);
    end

    pulse_start(32'd0, 32'd1);
    wait_valid(20, cyc, ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL dflt_timeout: valid=%b expected 1 within 20 cycles", vec_valid_o);
    end
    st = SEED_A;
    model_vec(st, exp);
    testsRun++;
    if (vec_o !== exp || rng_o !== st) begin
      testsFailed++;
      $display("[TB] FAIL dflt_vec: got %h rng=%h expected %h rng=%h", vec_o, rng_o, exp, st);
    end
    vec_ready_i = 1'b1;
    tick(1);
    vec_ready_i = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0]  st;
    logic [262:0] exp;
    int           cyc;
    bit           ok;
    do_reset();
    vec_ready_i = 1'b1;
    pulse_start(SEED_A, 32'd100);
    st = SEED_A;
    for (int k = 0; k < 100; k++) begin
      wait_valid(20, cyc, ok);
      testsRun++;
      if (!ok) begin
        testsFailed++;
        $display("[TB] FAIL stream_timeout: vector %0d valid=%b expected 1", k, vec_valid_o);
        break;
      end
      testsRun++;
      if (cyc !== 9) begin
        testsFailed++;
        $display("[TB] FAIL stream_latency: vector %0d took %0d cycles expected 9", k, cyc);
      end
      model_vec(st, exp);
      testsRun++;
      if (vec_o !== exp) begin
        testsFailed++;
        $display("[TB] FAIL stream_vec: vector %0d got %h expected %h", k, vec_o, exp);
      end
      tick(1);
      testsRun++;
      if (vec_count_o !== 32'(k + 1) || vec_valid_o !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL stream_accept: vector %0d count=%0d valid=%b expected %0d/0", k, vec_count_o, vec_valid_o, k + 1);
      end
    end
    vec_ready_i = 1'b0;
    testsRun++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || vec_count_o !== 32'd100 || rng_o !== st) begin
      testsFailed++;
      $display("[TB] FAIL stream_end: done=%b busy=%b count=%0d rng=%h expected 1/0/100/%h", done_o, busy_o, vec_count_o, rng_o, st);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0]  st;
    logic [262:0] exp;
    int           cyc;
    bit           ok;
    do_reset();
    pulse_start(32'h1234_5678, 32'd2);
    st = 32'h1234_5678;
    model_vec(st, exp);
    wait_valid(20, cyc, ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL bp_timeout: valid=%b expected 1", vec_valid_o);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1);
      testsRun++;
      if (vec_valid_o !== 1'b1 || vec_o !== exp || rng_o !== st || vec_count_o !== 32'd0) begin
        testsFailed++;
        $display("[TB] FAIL bp_hold: cycle %0d valid=%b rng=%h count=%0d expected 1/%h/0", i, vec_valid_o, rng_o, vec_count_o, st);
      end
    end
    vec_ready_i = 1'b1;
    tick(1);
    vec_ready_i = 1'b0;
    testsRun++;
    if (vec_count_o !== 32'd1 || vec_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL bp_accept: count=%0d valid=%b busy=%b expected 1/0/1", vec_count_o, vec_valid_o, busy_o);
    end
    model_vec(st, exp);
    wait_valid(20, cyc, ok);
    tick(3);
    testsRun++;
    if (!ok || vec_count_o !== 32'd1 || vec_o !== exp) begin
      testsFailed++;
      $display("[TB] FAIL bp_second: ok=%b count=%0d got %h expected 1 count=1 %h", ok, vec_count_o, vec_o, exp);
    end
    vec_ready_i = 1'b1;
    tick(1);
    vec_ready_i = 1'b0;
    testsRun++;
    if (vec_count_o !== 32'd2 || done_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL bp_done: count=%0d done=%b expected 2/1", vec_count_o, done_o);
    end
  endtask

  task automatic test_zero_vec();
    bit sawValid;
    int cyc;
    bit ok;
    do_reset();
    vec_ready_i = 1'b1;
    pulse_start(SEED_A, 32'd0);
    testsRun++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || vec_count_o !== 32'd0 || rng_o !== SEED_A) begin
      testsFailed++;
      $display("[TB] FAIL zero_done: done=%b busy=%b count=%0d rng=%h expected 1/0/0/%h", done_o, busy_o, vec_count_o, rng_o, SEED_A);
    end
    sawValid = 1'b0;
    repeat (15) begin
      tick(1);
      if (vec_valid_o !== 1'b0) sawValid = 1'b1;
    end
    testsRun++;
    if (sawValid || done_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL zero_novalid: sawValid=%b done=%b expected 0/1", sawValid, done_o);
    end
    pulse_start(SEED_A, 32'd1);
    testsRun++;
    if (done_o !== 1'b0 || busy_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL zero_restart: done=%b busy=%b expected 0/1", done_o, busy_o);
    end
    wait_valid(20, cyc, ok);
    tick(1);
    vec_ready_i = 1'b0;
    testsRun++;
    if (!ok || done_o !== 1'b1 || vec_count_o !== 32'd1) begin
      testsFailed++;
      $display("[TB] FAIL zero_rerun: ok=%b done=%b count=%0d expected 1/1/1", ok, done_o, vec_count_o);
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0]  st;
    logic [31:0]  mid;
    logic [262:0] exp;
    int           cyc;
    bit           ok;
    do_reset();
    pulse_start(SEED_A, 32'd3);
    st = SEED_A;
    tick(3);
    pulse_start(32'd1, 32'd5);
    mid = SEED_A;
    repeat (4) mid = model_step(mid);
    testsRun++;
    if (busy_o !== 1'b1 || rng_o !== mid) begin
      testsFailed++;
      $display("[TB] FAIL ign_fill: busy=%b rng=%h expected 1/%h", busy_o, rng_o, mid);
    end
    model_vec(st, exp);
    wait_valid(20, cyc, ok);
    testsRun++;
    if (!ok || cyc !== 5 || vec_o !== exp) begin
      testsFailed++;
      $display("[TB] FAIL ign_vec0: ok=%b cyc=%0d got %h expected 1/5/%h", ok, cyc, vec_o, exp);
    end
    pulse_start(32'd1, 32'd5);
    testsRun++;
    if (vec_valid_o !== 1'b1 || vec_o !== exp || rng_o !== st || vec_count_o !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL ign_hold: valid=%b rng=%h count=%0d expected 1/%h/0", vec_valid_o, rng_o, vec_count_o, st);
    end
    vec_ready_i = 1'b1;
    tick(1);
    for (int k = 1; k < 3; k++) begin
      model_vec(st, exp);
      wait_valid(20, cyc, ok);
      testsRun++;
      if (!ok || vec_o !== exp) begin
        testsFailed++;
        $display("[TB] FAIL ign_vec: vector %0d ok=%b got %h expected %h", k, ok, vec_o, exp);
      end
      tick(1);
    end
    vec_ready_i = 1'b0;
    testsRun++;
    if (vec_count_o !== 32'd3 || done_o !== 1'b1 || busy_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ign_end: count=%0d done=%b busy=%b expected 3/1/0", vec_count_o, done_o, busy_o);
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0]  st;
    logic [262:0] exp;
    int           cyc;
    bit           ok;
    do_reset();
    pulse_start(SEED_A, 32'd2);
    wait_valid(20, cyc, ok);
    vec_ready_i = 1'b1;
    tick(1);
    vec_ready_i = 1'b0;
    tick(3);
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (vec_o !== '0 || vec_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
        vec_count_o !== 32'd0 || rng_o !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL midrst_async: valid=%b busy=%b done=%b count=%0d rng=%h vecnz=%b expected all 0",
               vec_valid_o, busy_o, done_o, vec_count_o, rng_o, |vec_o);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    pulse_start(SEED_A, 32'd1);
    st = SEED_A;
    model_vec(st, exp);
    wait_valid(20, cyc, ok);
    testsRun++;
    if (!ok || cyc !== 9 || vec_o !== exp) begin
      testsFailed++;
      $display("[TB] FAIL midrst_replay: ok=%b cyc=%0d got %h expected 1/9/%h", ok, cyc, vec_o, exp);
    end
    vec_ready_i = 1'b1;
    tick(1);
    vec_ready_i = 1'b0;
    testsRun++;
    if (done_o !== 1'b1 || vec_count_o !== 32'd1) begin
      testsFailed++;
      $display("[TB] FAIL midrst_done: done=%b count=%0d expected 1/1", done_o, vec_count_o);
    end
  endtask

  initial begin
    test_reset();
    test_default_seed();
    test_stream();
    test_backpressure();
    test_zero_vec();
    test_start_ignored();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
